// File: rtl/dff_link_pkg.sv
// rtl/dff_link_pkg.sv - framing constants shared by the serial link transmitter and receiver
package dff_link_pkg;

    typedef logic [2:0] link_state_t;

    localparam link_state_t ST_IDLE   = 3'd0;
    localparam link_state_t ST_START  = 3'd1;
    localparam link_state_t ST_DATA   = 3'd2;
    localparam link_state_t ST_PARITY = 3'd3;
    localparam link_state_t ST_STOP   = 3'd4;

    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/dff_word_serializer_if.sv
// rtl/dff_word_serializer_if.sv - word handshake and serial line bundle for the word serializer
//
// data/valid : word offered by the parallel stage (master drives)
// ready      : serializer can take a word this cycle
// sout       : framed serial line, idles high
// busy       : a frame is in progress
// done       : one-cycle pulse in the final stop-bit cycle
interface dff_word_serializer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (
        output data, valid,
        input  ready, sout, busy, done
    );

    modport slave (
        input  data, valid,
        output ready, sout, busy, done
    );
endinterface

// File: rtl/dff_word_serializer.sv
// rtl/dff_word_serializer.sv - parallel word to framed serial line (start, data LSB first, optional even parity, stop)
//
// clk  : rising-edge clock
// rst  : asynchronous active-high reset; outputs return to idle at once
// link : slave side of dff_word_serializer_if (data/valid in; ready/sout/busy/done out)
//
// WIDTH     : word width, 1..32
// PARITY_EN : 1 inserts an even-parity bit after the data bits
module dff_word_serializer
    import dff_link_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    dff_word_serializer_if.slave  link
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    link_state_t      state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             par_q,   par_d;

    logic ready_int;
    logic accept;
    logic last_bit;

    // ready is a pure decode of the state flops, so it is glitch-free and
    // follows the asynchronous reset immediately.
    assign ready_int = (state_q == ST_IDLE) || (state_q == ST_STOP);
    assign accept    = link.valid && ready_int;
    assign last_bit  = (cnt_q == CNT_LAST);

    // State register and datapath flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_START;
            ST_START:  state_d = ST_DATA;
            ST_DATA:   if (last_bit) state_d = PARITY_EN ? ST_PARITY : ST_STOP;
            ST_PARITY: state_d = ST_STOP;
            ST_STOP:   state_d = accept ? ST_START : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Shift register, bit counter and parity capture. Parity is taken from
    // the word at the accept edge so later changes on data cannot leak in.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        if (accept) begin
            shift_d = link.data;
            par_d   = ^link.data;
            cnt_d   = '0;
        end else if (state_q == ST_START) begin
            cnt_d = '0;
        end else if (state_q == ST_DATA) begin
            shift_d = shift_q >> 1;
            cnt_d   = last_bit ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Output decode
    always_comb begin
        link.ready = ready_int;
        link.busy  = (state_q != ST_IDLE);
        link.done  = (state_q == ST_STOP);
        case (state_q)
            ST_START:  link.sout = START_LEVEL;
            ST_DATA:   link.sout = shift_q[0];
            ST_PARITY: link.sout = par_q;
            default:   link.sout = LINE_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dff_word_serializer.sv
// tb/tb_dff_word_serializer.sv - directed self-checking bench for dff_word_serializer
module tb_dff_word_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dff_word_serializer_if #(.WIDTH(4)) if0 ();
    dff_word_serializer_if #(.WIDTH(4)) if1 ();
    dff_word_serializer_if #(.WIDTH(1)) if2 ();

    dff_word_serializer #(.WIDTH(4), .PARITY_EN(1'b0)) dut0 (.clk(clk), .rst(rst), .link(if0));
    dff_word_serializer #(.WIDTH(4), .PARITY_EN(1'b1)) dut1 (.clk(clk), .rst(rst), .link(if1));
    dff_word_serializer #(.WIDTH(1), .PARITY_EN(1'b1)) dut2 (.clk(clk), .rst(rst), .link(if2));

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if0.data = 4'($urandom); if0.valid = 1'($urandom);
            if1.data = 4'($urandom); if1.valid = 1'($urandom);
            if2.data = 1'($urandom); if2.valid = 1'($urandom);
            #1;
            checks++;
            if ({if0.sout, if0.ready, if0.busy, if0.done} !== 4'b1100) begin
                errors++; $display("FAIL reset_dut0 cycle %0d: got %b want 1100", c, {if0.sout, if0.ready, if0.busy, if0.done});
            end
            checks++;
            if ({if1.sout, if1.ready, if1.busy, if1.done} !== 4'b1100) begin
                errors++; $display("FAIL reset_dut1 cycle %0d: got %b want 1100", c, {if1.sout, if1.ready, if1.busy, if1.done});
            end
            checks++;
            if ({if2.sout, if2.ready, if2.busy, if2.done} !== 4'b1100) begin
                errors++; $display("FAIL reset_dut2 cycle %0d: got %b want 1100", c, {if2.sout, if2.ready, if2.busy, if2.done});
            end
        end
        @(negedge clk);
        rst = 1'b0;
        if0.valid = 1'b0; if1.valid = 1'b0; if2.valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({if0.sout, if0.ready, if0.busy, if1.busy, if2.busy} !== 5'b11000) begin
            errors++; $display("FAIL reset_no_accept: got %b want 11000", {if0.sout, if0.ready, if0.busy, if1.busy, if2.busy});
        end
    endtask

    task automatic test_basic_frame();
        logic [5:0] exp_s;
        exp_s = 6'b110110;
        @(negedge clk);
        if0.data = 4'b1011; if0.valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) if0.valid = 1'b0;
            checks++;
            if ({if0.sout, if0.done} !== {exp_s[i], (i == 5)}) begin
                errors++; $display("FAIL basic_frame bit %0d: sout/done got %b want %b", i, {if0.sout, if0.done}, {exp_s[i], (i == 5)});
            end
        end
        @(negedge clk);
        checks++;
        if ({if0.sout, if0.ready, if0.busy, if0.done} !== 4'b1100) begin
            errors++; $display("FAIL basic_idle: got %b want 1100", {if0.sout, if0.ready, if0.busy, if0.done});
        end
    endtask

    task automatic test_parity_frame();
        logic [3:0] words [2];
        logic [6:0] exps  [2];
        logic [6:0] e;
        words[0] = 4'b0111; exps[0] = 7'b1101110;
        words[1] = 4'b0011; exps[1] = 7'b1000110;
        for (int v = 0; v < 2; v++) begin
            e = exps[v];
            @(negedge clk);
            if1.data = words[v]; if1.valid = 1'b1;
            for (int i = 0; i < 7; i++) begin
                @(negedge clk);
                if (i == 0) begin if1.valid = 1'b0; if1.data = ~words[v]; end
                checks++;
                if ({if1.sout, if1.done, if1.busy} !== {e[i], (i == 6), 1'b1}) begin
                    errors++; $display("FAIL parity_frame w%0d bit %0d: sout/done/busy got %b want %b", v, i, {if1.sout, if1.done, if1.busy}, {e[i], (i == 6), 1'b1});
                end
            end
            @(negedge clk);
            checks++;
            if ({if1.sout, if1.busy, if1.ready} !== 3'b101) begin
                errors++; $display("FAIL parity_idle w%0d: got %b want 101", v, {if1.sout, if1.busy, if1.ready});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_s;
        int n_done;
        int first_done;
        int second_done;
        exp_s = 12'b101010110100;
        n_done = 0; first_done = -1; second_done = -1;
        @(negedge clk);
        if0.data = 4'hA; if0.valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) if0.data = 4'h5;
            if (i == 6) if0.valid = 1'b0;
            checks++;
            if ({if0.sout, if0.ready} !== {exp_s[i], (i == 5 || i == 11)}) begin
                errors++; $display("FAIL back_to_back bit %0d: sout/ready got %b want %b", i, {if0.sout, if0.ready}, {exp_s[i], (i == 5 || i == 11)});
            end
            if (if0.done === 1'b1) begin
                if (n_done == 0) first_done = i; else second_done = i;
                n_done++;
            end
        end
        checks++;
        if (n_done != 2 || first_done != 5 || second_done != 11) begin
            errors++; $display("FAIL back_to_back_done: got count=%0d at %0d,%0d want count=2 at 5,11", n_done, first_done, second_done);
        end
        @(negedge clk);
        checks++;
        if ({if0.sout, if0.busy} !== 2'b10) begin
            errors++; $display("FAIL back_to_back_idle: got %b want 10", {if0.sout, if0.busy});
        end
    endtask

    task automatic test_hold_off();
        logic [11:0] exp_s;
        exp_s = 12'b111000110010;
        @(negedge clk);
        if0.data = 4'h9; if0.valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) begin if0.valid = 1'b0; if0.data = 4'h6; end
            else if (i >= 1 && i <= 4) begin if0.valid = 1'b1; if0.data = (i % 2 == 1) ? 4'h3 : 4'h6; end
            else if (i == 5) if0.data = 4'hC;
            else if (i == 6) begin if0.valid = 1'b0; if0.data = 4'h0; end
            checks++;
            if ({if0.sout, if0.ready, if0.done} !== {exp_s[i], (i == 5 || i == 11), (i == 5 || i == 11)}) begin
                errors++; $display("FAIL hold_off bit %0d: sout/ready/done got %b want %b", i, {if0.sout, if0.ready, if0.done}, {exp_s[i], (i == 5 || i == 11), (i == 5 || i == 11)});
            end
        end
        @(negedge clk);
        checks++;
        if ({if0.sout, if0.busy} !== 2'b10) begin
            errors++; $display("FAIL hold_off_idle: got %b want 10", {if0.sout, if0.busy});
        end
    endtask

    task automatic test_mid_frame_reset();
        logic [5:0] exp_s;
        exp_s = 6'b100110;
        @(negedge clk);
        if0.data = 4'hF; if0.valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) if0.valid = 1'b0;
        end
        checks++;
        if ({if0.sout, if0.ready, if0.busy} !== 3'b101) begin
            errors++; $display("FAIL mid_reset_preflight: got %b want 101", {if0.sout, if0.ready, if0.busy});
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({if0.sout, if0.ready, if0.busy, if0.done} !== 4'b1100) begin
            errors++; $display("FAIL mid_reset_async: got %b want 1100", {if0.sout, if0.ready, if0.busy, if0.done});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({if0.sout, if0.ready, if0.busy} !== 3'b110) begin
                errors++; $display("FAIL mid_reset_no_resend %0d: got %b want 110", i, {if0.sout, if0.ready, if0.busy});
            end
        end
        if0.data = 4'h3; if0.valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) if0.valid = 1'b0;
            checks++;
            if ({if0.sout, if0.done} !== {exp_s[i], (i == 5)}) begin
                errors++; $display("FAIL mid_reset_fresh bit %0d: got %b want %b", i, {if0.sout, if0.done}, {exp_s[i], (i == 5)});
            end
        end
    endtask

    task automatic test_width1();
        logic [7:0] exp_s;
        exp_s = 8'b10001110;
        @(negedge clk);
        if2.data = 1'b1; if2.valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) if2.data = 1'b0;
            if (i == 4) if2.valid = 1'b0;
            checks++;
            if ({if2.sout, if2.done, if2.ready} !== {exp_s[i], (i == 3 || i == 7), (i == 3 || i == 7)}) begin
                errors++; $display("FAIL width1 bit %0d: sout/done/ready got %b want %b", i, {if2.sout, if2.done, if2.ready}, {exp_s[i], (i == 3 || i == 7), (i == 3 || i == 7)});
            end
        end
        @(negedge clk);
        checks++;
        if ({if2.sout, if2.busy} !== 2'b10) begin
            errors++; $display("FAIL width1_idle: got %b want 10", {if2.sout, if2.busy});
        end
    endtask

    initial begin
        if0.data = '0; if0.valid = 1'b0;
        if1.data = '0; if1.valid = 1'b0;
        if2.data = '0; if2.valid = 1'b0;
        test_reset();
        test_basic_frame();
        test_parity_frame();
        test_back_to_back();
        test_hold_off();
        test_mid_frame_reset();
        test_width1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
